// File: rtl/pal_timing_pkg.sv
// Shared PAL 625/50 timing vocabulary: half-line pulse types, line boundaries
// of the vertical interval and the active-line windows of both fields.
package pal_timing_pkg;

   typedef enum logic [1:0] {
      PULSE_NONE  = 2'd0,
      PULSE_HSYNC = 2'd1,
      PULSE_EQ    = 2'd2,
      PULSE_BROAD = 2'd3
   } pulse_t;

   // Last line of each run of identical half-line pairs in the sync map
   localparam logic [9:0] LINE_FIRST          = 10'd1;
   localparam logic [9:0] LINE_BROAD_A_END    = 10'd3;
   localparam logic [9:0] LINE_PRE_EQ_END     = 10'd5;
   localparam logic [9:0] LINE_F1_VIDEO_END   = 10'd310;
   localparam logic [9:0] LINE_F2_START       = 10'd313;
   localparam logic [9:0] LINE_F2_POST_EQ_END = 10'd318;
   localparam logic [9:0] LINE_F2_VIDEO_END   = 10'd623;
   localparam logic [9:0] LINE_LAST           = 10'd625;

   localparam logic [9:0] ACT_F1_FIRST = 10'd23;
   localparam logic [9:0] ACT_F1_LAST  = 10'd310;
   localparam logic [9:0] ACT_F2_FIRST = 10'd336;
   localparam logic [9:0] ACT_F2_LAST  = 10'd622;

   function automatic logic in_range(input logic [9:0] v, input logic [9:0] lo,
                                     input logic [9:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/pal_csync_gen_if.sv
// Video timing bundle between the sync generator (master) and its consumers.
interface pal_csync_gen_if;
   logic       pixelEn;
   logic       resyncStrobe;
   logic       csync;
   logic       hsync;
   logic       vsync;
   logic       field;
   logic [9:0] lineNum;
   logic [9:0] sampleNum;
   logic       activeVideo;

   modport master (
      input  pixelEn, resyncStrobe,
      output csync, hsync, vsync, field, lineNum, sampleNum, activeVideo
   );

   modport slave (
      output pixelEn, resyncStrobe,
      input  csync, hsync, vsync, field, lineNum, sampleNum, activeVideo
   );
endinterface

// File: rtl/pal_halfline_decode.sv
// Maps a line number and half-line select onto the sync pulse carried by that
// half-line of the 625-line interlaced frame.
module pal_halfline_decode
   import pal_timing_pkg::*;
(
   input  logic [9:0] line_i,
   input  logic       half_b_i,
   output pulse_t     pulse_o
);

   // Half A carries line sync or the vertical-interval pulse; half B only the latter
   always_comb begin
      pulse_o = PULSE_NONE;
      if (!half_b_i) begin
         if (line_i <= LINE_BROAD_A_END)                   pulse_o = PULSE_BROAD;
         else if (line_i <= LINE_PRE_EQ_END)               pulse_o = PULSE_EQ;
         else if (line_i <= LINE_F1_VIDEO_END)             pulse_o = PULSE_HSYNC;
         else if (line_i <= LINE_F2_START)                 pulse_o = PULSE_EQ;
         else if (line_i <= LINE_F2_START + 10'd2)         pulse_o = PULSE_BROAD;
         else if (line_i <= LINE_F2_POST_EQ_END)           pulse_o = PULSE_EQ;
         else if (line_i <= LINE_F2_VIDEO_END)             pulse_o = PULSE_HSYNC;
         else                                              pulse_o = PULSE_EQ;
      end else begin
         if (line_i < LINE_BROAD_A_END)                    pulse_o = PULSE_BROAD;
         else if (line_i <= LINE_PRE_EQ_END)               pulse_o = PULSE_EQ;
         else if (line_i <= LINE_F1_VIDEO_END)             pulse_o = PULSE_NONE;
         else if (line_i < LINE_F2_START)                  pulse_o = PULSE_EQ;
         else if (line_i <= LINE_F2_START + 10'd2)         pulse_o = PULSE_BROAD;
         else if (line_i < LINE_F2_POST_EQ_END)            pulse_o = PULSE_EQ;
         else if (line_i < LINE_F2_VIDEO_END)              pulse_o = PULSE_NONE;
         else                                              pulse_o = PULSE_EQ;
      end
   end

endmodule

// File: rtl/pal_csync_gen.sv
// PAL 625-line interlaced composite sync generator with line/field timing,
// phase-lockable to an external frame start through resyncStrobe.
module pal_csync_gen
   import pal_timing_pkg::*;
#(
   parameter int H_TOTAL   = 864,
   parameter int HSYNC_LEN = 63,
   parameter int EQ_LEN    = 32,
   parameter int BROAD_LEN = 369,
   parameter int ACT_START = 132,
   parameter int ACT_LEN   = 720
) (
   input logic             sysClock,
   input logic             nReset,
   pal_csync_gen_if.master vid
);

   localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0] H_HALF    = 10'(H_TOTAL / 2);
   localparam logic [9:0] HS_W      = 10'(HSYNC_LEN);
   localparam logic [9:0] EQ_W      = 10'(EQ_LEN);
   localparam logic [9:0] BR_W      = 10'(BROAD_LEN);
   localparam logic [9:0] ACT_FIRST = 10'(ACT_START);
   localparam logic [9:0] ACT_LAST  = 10'(ACT_START + ACT_LEN - 1);

   logic [9:0] line_q, line_d, sample_q, sample_d;
   logic       pend_q, pend_d;
   logic       csync_q, csync_d, hsync_q, hsync_d, vsync_q, vsync_d;
   logic       field_q, field_d, active_q, active_d;
   logic       half_b_s;
   logic [9:0] offset_s, pulse_len_s;
   pulse_t     pulse_s;

   // Counter advance; a pending or same-edge resync overrides the normal wrap
   always_comb begin
      line_d   = line_q;
      sample_d = sample_q;
      pend_d   = pend_q | vid.resyncStrobe;
      if (vid.pixelEn) begin
         pend_d = 1'b0;
         if (pend_q | vid.resyncStrobe) begin
            line_d   = LINE_FIRST;
            sample_d = 10'd0;
         end else if (sample_q == H_LAST) begin
            sample_d = 10'd0;
            if (line_q == LINE_LAST) begin
               line_d = LINE_FIRST;
            end else begin
               line_d = line_q + 10'd1;
            end
         end else begin
            sample_d = sample_q + 10'd1;
         end
      end else begin
         pend_d = pend_q | vid.resyncStrobe;
      end
   end

   assign half_b_s = (sample_d >= H_HALF);
   assign offset_s = half_b_s ? (sample_d - H_HALF) : sample_d;

   pal_halfline_decode u_decode (
      .line_i   (line_d),
      .half_b_i (half_b_s),
      .pulse_o  (pulse_s)
   );

   // Outputs are decoded from the sample being loaded so they carry no extra latency
   always_comb begin
      case (pulse_s)
         PULSE_HSYNC: pulse_len_s = HS_W;
         PULSE_EQ:    pulse_len_s = EQ_W;
         PULSE_BROAD: pulse_len_s = BR_W;
         default:     pulse_len_s = 10'd0;
      endcase
      csync_d  = (offset_s < pulse_len_s) ? 1'b0 : 1'b1;
      hsync_d  = (sample_d == 10'd0);
      vsync_d  = (line_d <= LINE_PRE_EQ_END) ||
                 in_range(line_d, LINE_F2_START, LINE_F2_START + 10'd4);
      field_d  = (line_d >= LINE_F2_START);
      active_d = in_range(sample_d, ACT_FIRST, ACT_LAST) &&
                 (in_range(line_d, ACT_F1_FIRST, ACT_F1_LAST) ||
                  in_range(line_d, ACT_F2_FIRST, ACT_F2_LAST));
   end

   // State and output registers; reset parks the counters one sample before frame start
   always_ff @(posedge sysClock or negedge nReset) begin
      if (!nReset) begin
         line_q   <= LINE_LAST;
         sample_q <= H_LAST;
         pend_q   <= 1'b0;
         csync_q  <= 1'b1;
         hsync_q  <= 1'b0;
         vsync_q  <= 1'b0;
         field_q  <= 1'b1;
         active_q <= 1'b0;
      end else begin
         line_q   <= line_d;
         sample_q <= sample_d;
         pend_q   <= pend_d;
         if (vid.pixelEn) begin
            csync_q  <= csync_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            field_q  <= field_d;
            active_q <= active_d;
         end
      end
   end

   assign vid.csync       = csync_q;
   assign vid.hsync       = hsync_q;
   assign vid.vsync       = vsync_q;
   assign vid.field       = field_q;
   assign vid.activeVideo = active_q;
   assign vid.lineNum     = line_q;
   assign vid.sampleNum   = sample_q;

endmodule

// File: tb/tb_pal_csync_gen.sv
// Scoreboard bench: a reduced-line-length instance covers whole frames, a
// full-size instance runs in lockstep for the real pulse widths.
module tb_pal_csync_gen;

   localparam int SH = 64,  SHS = 5,  SEQ = 2,  SBR = 27,  SAS = 10,  SAL = 50;
   localparam int BH = 864, BHS = 63, BEQ = 32, BBR = 369, BAS = 132, BAL = 720;

   typedef struct packed {
      logic       csync;
      logic       hsync;
      logic       vsync;
      logic       field;
      logic       active;
      logic [9:0] line;
      logic [9:0] samp;
   } exp_t;

   localparam exp_t RST_S = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'd625, 10'd63};
   localparam exp_t RST_B = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'd625, 10'd863};

   // Sync map rows: first line, last line, half-A type, half-B type (0 none 1 hsync 2 eq 3 broad)
   int map_lo [12] = '{1, 3, 4, 6,   311, 313, 314, 316, 318, 319, 623, 624};
   int map_hi [12] = '{2, 3, 5, 310, 312, 313, 315, 317, 318, 622, 623, 625};
   int map_a  [12] = '{3, 3, 2, 1,   2,   2,   3,   2,   2,   1,   1,   2};
   int map_b  [12] = '{3, 2, 2, 0,   2,   3,   3,   2,   0,   0,   2,   2};

   logic clk = 1'b0;
   logic nReset = 1'b0;
   int   vectors = 0;
   int   fails = 0;
   int   hs_cnt = 0;
   logic prev_field = 1'b1;
   int   s_line = 625, s_samp = SH - 1, b_line = 625, b_samp = BH - 1;
   bit   pend = 1'b0;
   exp_t q_s[$];
   exp_t q_b[$];
   exp_t last_s = RST_S;
   exp_t last_b = RST_B;

   pal_csync_gen_if vs();
   pal_csync_gen_if vb();

   pal_csync_gen #(.H_TOTAL(SH), .HSYNC_LEN(SHS), .EQ_LEN(SEQ), .BROAD_LEN(SBR),
                   .ACT_START(SAS), .ACT_LEN(SAL))
      dut_s (.sysClock(clk), .nReset(nReset), .vid(vs.master));

   pal_csync_gen #(.H_TOTAL(BH), .HSYNC_LEN(BHS), .EQ_LEN(BEQ), .BROAD_LEN(BBR),
                   .ACT_START(BAS), .ACT_LEN(BAL))
      dut_b (.sysClock(clk), .nReset(nReset), .vid(vb.master));

   always #5 clk = ~clk;

   function automatic exp_t calc(int ln, int sp, int ht, int hsl, int eql, int brl,
                                 int ast, int aln);
      exp_t e;
      int half, off, ty, len;
      half = ht / 2;
      ty   = 0;
      for (int r = 0; r < 12; r++)
         if (ln >= map_lo[r] && ln <= map_hi[r]) ty = (sp < half) ? map_a[r] : map_b[r];
      off = (sp < half) ? sp : sp - half;
      case (ty)
         1:       len = hsl;
         2:       len = eql;
         3:       len = brl;
         default: len = 0;
      endcase
      e.csync  = (off < len) ? 1'b0 : 1'b1;
      e.hsync  = (sp == 0);
      e.vsync  = (ln <= 5) || (ln >= 313 && ln <= 317);
      e.field  = (ln >= 313);
      e.active = (sp >= ast && sp < ast + aln) &&
                 ((ln >= 23 && ln <= 310) || (ln >= 336 && ln <= 622));
      e.line   = 10'(ln);
      e.samp   = 10'(sp);
      return e;
   endfunction

   function automatic exp_t got_s();
      return '{vs.csync, vs.hsync, vs.vsync, vs.field, vs.activeVideo, vs.lineNum, vs.sampleNum};
   endfunction

   function automatic exp_t got_b();
      return '{vb.csync, vb.hsync, vb.vsync, vb.field, vb.activeVideo, vb.lineNum, vb.sampleNum};
   endfunction

   task automatic check(input string nm, input exp_t g, input exp_t e);
      vectors++;
      if (g !== e) begin
         fails++;
         $display("FAIL %s: got cs=%b hs=%b vs=%b fd=%b av=%b line=%0d samp=%0d, need cs=%b hs=%b vs=%b fd=%b av=%b line=%0d samp=%0d",
                  nm, g.csync, g.hsync, g.vsync, g.field, g.active, g.line, g.samp,
                  e.csync, e.hsync, e.vsync, e.field, e.active, e.line, e.samp);
      end
   endtask

   task automatic adv(inout int ln, inout int sp, input int ht);
      if (sp == ht - 1) begin
         sp = 0;
         ln = (ln == 625) ? 1 : ln + 1;
      end else begin
         sp++;
      end
   endtask

   // Drive inputs for the next edge and queue what that edge must produce
   task automatic cyc(input bit en, input bit rs);
      vs.pixelEn = en;      vb.pixelEn = en;
      vs.resyncStrobe = rs; vb.resyncStrobe = rs;
      if (en) begin
         if (pend || rs) begin
            s_line = 1; s_samp = 0; b_line = 1; b_samp = 0;
         end else begin
            adv(s_line, s_samp, SH);
            adv(b_line, b_samp, BH);
         end
         pend = 1'b0;
         q_s.push_back(calc(s_line, s_samp, SH, SHS, SEQ, SBR, SAS, SAL));
         q_b.push_back(calc(b_line, b_samp, BH, BHS, BEQ, BBR, BAS, BAL));
      end else if (rs) begin
         pend = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      #2;
      nReset = 1'b0;
      vs.pixelEn = 1'b0;      vb.pixelEn = 1'b0;
      vs.resyncStrobe = 1'b0; vb.resyncStrobe = 1'b0;
      #1;
      check("rst_small", got_s(), RST_S);
      check("rst_big", got_b(), RST_B);
      pend = 1'b0;
      s_line = 625; s_samp = SH - 1; b_line = 625; b_samp = BH - 1;
      q_s.delete(); q_b.delete();
      last_s = RST_S; last_b = RST_B;
      prev_field = 1'b1;
      hs_cnt = 0;
      repeat (n) cyc(1'b0, 1'b0);
      #2;
      nReset = 1'b1;
   endtask

   initial begin : monitor
      bit en_seen, rst_seen;
      forever begin
         @(posedge clk);
         en_seen  = vs.pixelEn;
         rst_seen = nReset;
         #2;
         if (rst_seen && en_seen) begin
            if (q_s.size() == 0 || q_b.size() == 0) begin
               vectors++; fails++;
               $display("FAIL scoreboard: got empty expect queue, need one entry per enabled edge");
            end else begin
               last_s = q_s.pop_front();
               last_b = q_b.pop_front();
               check("small", got_s(), last_s);
               check("big", got_b(), last_b);
               if (vs.hsync === 1'b1) hs_cnt++;
               if (vs.field !== prev_field) begin
                  vectors++;
                  if (!(vs.sampleNum == 10'd0 && vs.lineNum == (vs.field ? 10'd313 : 10'd1))) begin
                     fails++;
                     $display("FAIL field_edge: got field=%b at line=%0d samp=%0d, need line %0d samp 0",
                              vs.field, vs.lineNum, vs.sampleNum, vs.field ? 313 : 1);
                  end
                  prev_field = vs.field;
               end
            end
         end else if (rst_seen) begin
            check("small_hold", got_s(), last_s);
            check("big_hold", got_b(), last_b);
         end
      end
   end

   initial begin
      vs.pixelEn = 1'b0;      vb.pixelEn = 1'b0;
      vs.resyncStrobe = 1'b0; vb.resyncStrobe = 1'b0;
      @(posedge clk);
      #1;
      do_reset(3);
      repeat (2) cyc(1'b0, 1'b0);

      // Whole frame of the reduced instance
      repeat (625 * SH) cyc(1'b1, 1'b0);
      #2;
      vectors++;
      if (hs_cnt != 625) begin
         fails++;
         $display("FAIL hsync_count: got %0d strobes, need 625", hs_cnt);
      end

      // Resync on the last sample of line 7 must not take the wrap to line 8
      while (!(s_line == 7 && s_samp == SH - 1)) cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b1);

      // Two strobes while disabled collapse into one restart
      repeat (300) cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b0);
      repeat (50) cyc(1'b1, 1'b0);

      // Mid-line resync with the enable running
      repeat (1000) cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b1);
      repeat (20) cyc(1'b1, 1'b0);

      // 1-in-6 enable with a strobe landing on a disabled cycle
      for (int i = 0; i < 3600; i++) cyc((i % 6) == 0, i == 1000);

      // Reset asserted inside the line-1 broad pulse
      cyc(1'b1, 1'b1);
      repeat (20) cyc(1'b1, 1'b0);
      do_reset(2);
      repeat (2) cyc(1'b0, 1'b0);
      repeat (200) cyc(1'b1, 1'b0);
      #2;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
